// File: rtl/imm_gen.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen
// Brief    : RV32I immediate generator; decodes format from opcode, registers
//            the sign-extended immediate for the ALU mux and target adders.
// Revision : 1.0 - initial release
// ============================================================================
module imm_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  output logic [31:0] imm_out
);

  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_FENCE  = 7'b0001111;
  localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } fmt_e;

  fmt_e        w_fmt;
  logic        w_sign;
  logic [31:0] w_imm_d;
  logic [31:0] r_imm_q;

  assign w_sign = instr[31];

  // funct3/funct7 are deliberately ignored: shift-immediates decode as plain I.
  always_comb begin
    w_fmt = FMT_NONE;
    case (instr[6:0])
      c_OP_LOAD, c_OP_IMM, c_OP_JALR,
      c_OP_FENCE, c_OP_SYSTEM:        w_fmt = FMT_I;
      c_OP_STORE:                     w_fmt = FMT_S;
      c_OP_BRANCH:                    w_fmt = FMT_B;
      c_OP_LUI, c_OP_AUIPC:           w_fmt = FMT_U;
      c_OP_JAL:                       w_fmt = FMT_J;
      default:                        w_fmt = FMT_NONE;
    endcase
  end

  always_comb begin
    w_imm_d = 32'h0000_0000;
    case (w_fmt)
      FMT_I:   w_imm_d = {{20{w_sign}}, instr[31:20]};
      FMT_S:   w_imm_d = {{20{w_sign}}, instr[31:25], instr[11:7]};
      FMT_B:   w_imm_d = {{19{w_sign}}, instr[31], instr[7], instr[30:25],
                          instr[11:8], 1'b0};
      FMT_U:   w_imm_d = {instr[31:12], 12'b0};
      FMT_J:   w_imm_d = {{11{w_sign}}, instr[31], instr[19:12], instr[20],
                          instr[30:21], 1'b0};
      default: w_imm_d = 32'h0000_0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_imm_q <= 32'h0000_0000;
    end else begin
      r_imm_q <= w_imm_d;
    end
  end

  assign imm_out = r_imm_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen.sv
`default_nettype none
// Self-checking bench for imm_gen: directed vectors, reset behaviour and
// randomized instructions against an arithmetic reference model.
module tb_imm_gen;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic [31:0] imm_out;

  int unsigned n_total;
  int unsigned n_bad;

  imm_gen u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .instr   (instr),
    .imm_out (imm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // Reference: build the immediate as a signed integer from weighted fields.
  function automatic logic [31:0] ref_imm(input logic [31:0] x);
    longint v;
    longint s;
    s = x[31] ? 1 : 0;
    v = 0;
    case (x[6:0])
      7'h03, 7'h13, 7'h67, 7'h0f, 7'h73:
        v = -s * 2048 + longint'(x[30:20]);
      7'h23:
        v = -s * 2048 + longint'(x[30:25]) * 32 + longint'(x[11:7]);
      7'h63:
        v = -s * 4096 + longint'(x[7]) * 2048 + longint'(x[30:25]) * 32
            + longint'(x[11:8]) * 2;
      7'h37, 7'h17:
        v = longint'(x[31:12]) * 4096;
      7'h6f:
        v = -s * 1048576 + longint'(x[19:12]) * 4096 + longint'(x[20]) * 2048
            + longint'(x[30:21]) * 2;
      default:
        v = 0;
    endcase
    return v[31:0];
  endfunction

  task automatic apply(input string tag, input logic [31:0] ins, input logic [31:0] exp);
    @(negedge clk);
    instr = ins;
    @(posedge clk);
    #1;
    check(tag, imm_out, exp);
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];
  logic [6:0] ops[10] = '{7'h03, 7'h13, 7'h67, 7'h0f, 7'h73,
                          7'h23, 7'h63, 7'h37, 7'h17, 7'h6f};

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b1;
    instr   = 32'h0;

    // Get a nonzero value onto the output before the first reset.
    apply("pre_reset_lui", 32'h12345637, 32'h12345000);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", imm_out, 32'h0);
    instr = 32'habcdef97;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", imm_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_no_edge", imm_out, 32'h0);
    @(posedge clk);
    #1;
    check("first_after_release", imm_out, 32'habcde000);

    vecs.push_back('{32'h00000000, 32'h00000000});
    vecs.push_back('{32'h6cdff6e7, 32'h000006cd});
    vecs.push_back('{32'h8cdff603, 32'hfffff8cd});
    vecs.push_back('{32'h02dff6a3, 32'h0000002d});
    vecs.push_back('{32'ha2dff623, 32'hfffffa2c});
    vecs.push_back('{32'h75834863, 32'h00000750});
    vecs.push_back('{32'hf1eed7e3, 32'hffffff0e});
    vecs.push_back('{32'h12345637, 32'h12345000});
    vecs.push_back('{32'habcdef97, 32'habcde000});
    vecs.push_back('{32'h6669996f, 32'h00099666});
    vecs.push_back('{32'h888888ef, 32'hfff88088});
    vecs.push_back('{32'hffffff7f, 32'h00000000});
    vecs.push_back('{32'h40515293, 32'h00000405});
    vecs.push_back('{32'hfff00073, 32'hffffffff});
    foreach (vecs[i]) begin
      apply($sformatf("dir%0d", i), vecs[i].ins, vecs[i].exp);
      check($sformatf("model_dir%0d", i), ref_imm(vecs[i].ins), vecs[i].exp);
    end

    // Random back-to-back with a glitch mid-cycle; only the edge value counts.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] r;
      r = $urandom();
      if (i % 4 != 0) r[6:0] = ops[$urandom_range(0, 9)];
      @(negedge clk);
      instr = $urandom();
      #2;
      instr = r;
      @(posedge clk);
      #1;
      check($sformatf("rnd%0d", i), imm_out, ref_imm(r));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
